// File: rtl/apu_fetch_pkg.sv
// Shared types and default sizing for the multi-channel sample fetcher.
package apu_fetch_pkg;

  localparam int unsigned DEF_CHANNELS   = 4;
  localparam int unsigned DEF_DATA_W     = 64;
  localparam int unsigned DEF_ADDR_W     = 29;
  localparam int unsigned DEF_LEN_W      = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/chunk_fifo.sv
// Per-channel chunk buffer: synchronous FIFO with flush; flush beats push and pop.
module chunk_fifo #(
  parameter  int unsigned DATA_W     = 64,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/multi_sample_fetcher.sv
// Streams 64-bit sample chunks from memory into per-channel FIFOs through one
// shared, round-robin arbitrated read port with a single outstanding read.
module multi_sample_fetcher
  import apu_fetch_pkg::*;
#(
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [CHANNELS*ADDR_W-1:0] i_base,
  input  logic [CHANNELS*LEN_W-1:0]  i_length,
  input  logic [CHANNELS-1:0]        i_loop,
  input  logic [CHANNELS-1:0]        i_base_valid,
  output logic [CHANNELS-1:0]        o_base_ack,
  input  logic [CHANNELS-1:0]        i_stop,
  output logic [CHANNELS-1:0]        o_done,
  output logic [CHANNELS*DATA_W-1:0] o_chunk,
  output logic [CHANNELS-1:0]        o_chunk_valid,
  input  logic [CHANNELS-1:0]        i_chunk_ack,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic                       o_mem_read_en,
  input  logic                       i_mem_wait,
  input  logic [DATA_W-1:0]          i_mem_data,
  input  logic                       i_mem_ack
);

  localparam int unsigned OWN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRED_W = CNT_W + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [OWN_W-1:0]  r_owner;
  logic [OWN_W-1:0]  r_rr_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [OWN_W-1:0]  w_grant;
  logic              w_grant_any;
  logic              w_ack_take;
  logic [CHANNELS-1:0] w_eligible;
  logic [ADDR_W-1:0] w_cur_addr [CHANNELS];

  assign w_ack_take = (r_state == WAIT_DATA) && i_mem_ack;

  // Per-channel stream state, credit check and chunk buffer.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic              r_active;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_done;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_head;
    logic              w_inflight;
    logic              w_push;
    logic              w_arm;

    assign w_inflight = (r_state != IDLE) && (r_owner == OWN_W'(g));
    assign w_arm      = i_base_valid[g] && o_base_ack[g];
    assign w_push     = w_ack_take && w_inflight && r_active && !i_stop[g];

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_active    <= 1'b0;
        r_cur_addr  <= '0;
        r_remaining <= '0;
        r_done      <= 1'b0;
      end else begin
        r_done <= 1'b0;
        if (i_stop[g]) begin
          r_active <= 1'b0;
        end else if (w_push) begin
          if (r_remaining == LEN_W'(1)) begin
            if (i_loop[g]) begin
              r_cur_addr  <= i_base[g*ADDR_W +: ADDR_W];
              r_remaining <= i_length[g*LEN_W +: LEN_W];
            end else begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_cur_addr  <= r_cur_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
          end
        end else if (w_arm) begin
          r_active    <= 1'b1;
          r_cur_addr  <= i_base[g*ADDR_W +: ADDR_W];
          r_remaining <= i_length[g*LEN_W +: LEN_W];
        end
      end
    end

    chunk_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_push (w_push),
      .i_data (i_mem_data),
      .i_pop  (i_chunk_ack[g]),
      .i_flush(i_stop[g]),
      .o_data (w_head),
      .o_count(w_count)
    );

    // Credit = buffered chunks plus the read in flight, reserved at grant.
    assign w_eligible[g] = r_active && !i_stop[g] &&
                           ((CRED_W'(w_count) + CRED_W'(w_inflight)) < CRED_W'(FIFO_DEPTH));
    assign o_base_ack[g] = !i_reset && !r_active && !w_inflight;
    assign o_chunk[g*DATA_W +: DATA_W] = (w_count != '0) ? w_head : '0;
    assign o_chunk_valid[g] = (w_count != '0);
    assign o_done[g]        = r_done;
    assign w_cur_addr[g]    = r_cur_addr;
  end

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant     = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (!w_grant_any && w_eligible[OWN_W'((int'(r_rr_ptr) + k) % int'(CHANNELS))]) begin
        w_grant_any = 1'b1;
        w_grant     = OWN_W'((int'(r_rr_ptr) + k) % int'(CHANNELS));
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_grant_any) w_next_state = REQ;
      REQ:       if (!i_mem_wait) w_next_state = WAIT_DATA;
      WAIT_DATA: if (i_mem_ack)   w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_mem_read_en = 1'b0;
    o_mem_addr    = '0;
    if (r_state == REQ) begin
      o_mem_read_en = 1'b1;
      o_mem_addr    = r_addr;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_addr   <= '0;
    end else if ((r_state == IDLE) && w_grant_any) begin
      r_owner  <= w_grant;
      r_addr   <= w_cur_addr[w_grant];
      r_rr_ptr <= (w_grant == OWN_W'(CHANNELS - 1)) ? '0 : w_grant + OWN_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_sample_fetcher.sv
// Scoreboard bench: a memory responder records accepted reads; scenario tasks
// push expected addresses/chunks and compare them as the DUT produces them.
module tb_multi_sample_fetcher;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 29;
  localparam int unsigned LW = 16;

  logic            clock;
  logic            reset;
  logic [CH*AW-1:0] base;
  logic [CH*LW-1:0] length;
  logic [CH-1:0]   loop_en, base_valid, base_ack, stop, done, chunk_valid, chunk_ack;
  logic [CH*DW-1:0] chunk;
  logic [AW-1:0]   mem_addr;
  logic            mem_read_en, mem_wait, mem_ack;
  logic [DW-1:0]   mem_data;

  int n_pass = 0;
  int n_total = 0;
  int ack_delay = 2;
  bit wait_toggle = 1'b0;
  int done_cnt [CH];
  logic [AW-1:0] q_req_addr [$];
  logic [AW-1:0] q_exp_addr [$];
  logic [DW-1:0] q_exp_data [$];

  multi_sample_fetcher dut (
    .i_clock(clock), .i_reset(reset), .i_base(base), .i_length(length),
    .i_loop(loop_en), .i_base_valid(base_valid), .o_base_ack(base_ack),
    .i_stop(stop), .o_done(done), .o_chunk(chunk), .o_chunk_valid(chunk_valid),
    .i_chunk_ack(chunk_ack), .o_mem_addr(mem_addr), .o_mem_read_en(mem_read_en),
    .i_mem_wait(mem_wait), .i_mem_data(mem_data), .i_mem_ack(mem_ack)
  );

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {32'hA5A5_0000 ^ 32'(a), 3'b000, a};
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < CH; c++) done_cnt[c] = 0;
    forever begin
      @(negedge clock);
      for (int c = 0; c < CH; c++) if (done[c] === 1'b1) done_cnt[c]++;
    end
  end

  // Memory model: records each accepted read and returns mem_fn(addr) later.
  initial begin
    int wcnt;
    logic [AW-1:0] a;
    wcnt = 0;
    mem_ack = 1'b0; mem_wait = 1'b0; mem_data = '0;
    forever begin
      @(negedge clock);
      wcnt++;
      mem_wait = wait_toggle && (((wcnt / 3) % 2) == 1);
      if (!reset && mem_read_en === 1'b1 && !mem_wait) begin
        a = mem_addr;
        q_req_addr.push_back(a);
        repeat (ack_delay) @(negedge clock);
        mem_ack = 1'b1;
        mem_data = mem_fn(a);
        @(negedge clock);
        mem_ack = 1'b0;
      end
    end
  end

  task automatic arm(input int ch, input logic [AW-1:0] b, input logic [LW-1:0] l, input logic lp);
    base[ch*AW +: AW]   = b;
    length[ch*LW +: LW] = l;
    loop_en[ch]         = lp;
    base_valid[ch]      = 1'b1;
  endtask

  task automatic wait_chunk(input int ch, input int budget, output bit got, output logic [DW-1:0] d);
    got = 1'b0;
    d = '0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clock);
      if (chunk_valid[ch]) begin
        got = 1'b1;
        d = chunk[ch*DW +: DW];
        chunk_ack[ch] = 1'b1;
        @(negedge clock);
        chunk_ack[ch] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    base_valid = '0; stop = '0; chunk_ack = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    q_req_addr.delete(); q_exp_addr.delete(); q_exp_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    base = '0; length = '0; loop_en = '0; base_valid = '0; stop = '0; chunk_ack = '0;
    repeat (3) @(negedge clock);
    n_total++;
    if ({mem_read_en, mem_addr, base_ack, chunk_valid, done} !== '0)
      $display("FAIL reset_outputs: got rd=%b addr=%h ack=%b cv=%b done=%b required all 0",
               mem_read_en, mem_addr, base_ack, chunk_valid, done);
    else n_pass++;
    n_total++;
    if (chunk !== '0) $display("FAIL reset_chunk: got %h required 0", chunk); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (base_ack !== 4'hF) $display("FAIL reset_base_ack: got %b required 1111", base_ack); else n_pass++;
    n_total++;
    if (mem_read_en !== 1'b0) $display("FAIL reset_idle_read: got %b required 0", mem_read_en); else n_pass++;
  endtask

  task automatic test_single();
    bit got; logic [DW-1:0] d, e; logic [AW-1:0] a, ea; int d0;
    d0 = done_cnt[0];
    ack_delay = 2;
    for (int k = 0; k < 3; k++) begin
      q_exp_addr.push_back(AW'(32'h100 + k));
      q_exp_data.push_back(mem_fn(AW'(32'h100 + k)));
    end
    @(negedge clock);
    arm(0, 29'h100, 16'd3, 1'b0);
    @(negedge clock);
    base_valid = '0;
    n_total++;
    if (mem_read_en !== 1'b0 || base_ack[0] !== 1'b0)
      $display("FAIL single_arm_edge: got rd=%b ack=%b required rd=0 ack=0", mem_read_en, base_ack[0]);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (mem_read_en !== 1'b1 || mem_addr !== 29'h100)
      $display("FAIL single_first_req: got rd=%b addr=%h required rd=1 addr=100", mem_read_en, mem_addr);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      wait_chunk(0, 40, got, d);
      e = q_exp_data.pop_front();
      n_total++;
      if (!got || d !== e) $display("FAIL single_chunk%0d: got %h (valid=%b) required %h", k, d, got, e);
      else n_pass++;
    end
    repeat (6) @(negedge clock);
    n_total++;
    if (q_req_addr.size() != 3) $display("FAIL single_read_count: got %0d required 3", q_req_addr.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
      ea = q_exp_addr.pop_front();
      n_total++;
      if (a !== ea) $display("FAIL single_addr%0d: got %h required %h", k, a, ea); else n_pass++;
    end
    n_total++;
    if (done_cnt[0] - d0 != 1 || base_ack[0] !== 1'b1)
      $display("FAIL single_done: got pulses=%0d ack=%b required pulses=1 ack=1", done_cnt[0] - d0, base_ack[0]);
    else n_pass++;
    q_req_addr.delete();
  endtask

  task automatic test_backpressure();
    bit got; logic [DW-1:0] d; logic [AW-1:0] a;
    @(negedge clock);
    arm(1, 29'h40, 16'd10, 1'b0);
    @(negedge clock);
    base_valid = '0;
    repeat (40) @(negedge clock);
    n_total++;
    if (q_req_addr.size() != 4 || mem_read_en !== 1'b0)
      $display("FAIL bp_full_reads: got %0d reads rd=%b required 4 reads rd=0", q_req_addr.size(), mem_read_en);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
      n_total++;
      if (a !== AW'(32'h40 + k)) $display("FAIL bp_addr%0d: got %h required %h", k, a, AW'(32'h40 + k));
      else n_pass++;
    end
    wait_chunk(1, 5, got, d);
    n_total++;
    if (!got || d !== mem_fn(29'h40)) $display("FAIL bp_pop: got %h required %h", d, mem_fn(29'h40));
    else n_pass++;
    repeat (20) @(negedge clock);
    n_total++;
    if (q_req_addr.size() != 1 || mem_read_en !== 1'b0)
      $display("FAIL bp_one_more: got %0d reads rd=%b required 1 read rd=0", q_req_addr.size(), mem_read_en);
    else n_pass++;
    a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
    n_total++;
    if (a !== 29'h44) $display("FAIL bp_next_addr: got %h required 44", a); else n_pass++;
    stop[1] = 1'b1;
    @(negedge clock);
    stop[1] = 1'b0;
    n_total++;
    if (chunk_valid[1] !== 1'b0 || base_ack[1] !== 1'b1)
      $display("FAIL bp_stop_flush: got cv=%b ack=%b required cv=0 ack=1", chunk_valid[1], base_ack[1]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit got; logic [DW-1:0] d, e; logic [AW-1:0] a; int snap [CH];
    do_reset();
    ack_delay = 2;
    for (int c = 0; c < CH; c++) snap[c] = done_cnt[c];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++) q_exp_addr.push_back(AW'(c * 32'h100 + r));
    for (int c = 0; c < CH; c++) arm(c, AW'(c * 32'h100), 16'd2, 1'b0);
    @(negedge clock);
    base_valid = '0;
    for (int k = 0; k < 120 && q_req_addr.size() < 8; k++) @(negedge clock);
    n_total++;
    if (q_req_addr.size() != 8) $display("FAIL rr_read_count: got %0d required 8", q_req_addr.size());
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
      e = DW'(q_exp_addr.pop_front());
      n_total++;
      if (DW'(a) !== e) $display("FAIL rr_order%0d: got %h required %h", k, a, e[AW-1:0]); else n_pass++;
    end
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 2; r++) begin
        wait_chunk(c, 10, got, d);
        e = mem_fn(AW'(c * 32'h100 + r));
        n_total++;
        if (!got || d !== e) $display("FAIL rr_chunk_c%0d_%0d: got %h required %h", c, r, d, e);
        else n_pass++;
      end
    repeat (2) @(negedge clock);
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (done_cnt[c] - snap[c] != 1) $display("FAIL rr_done_c%0d: got %0d required 1", c, done_cnt[c] - snap[c]);
      else n_pass++;
    end
  endtask

  task automatic test_loop();
    bit got; logic [DW-1:0] d; logic [AW-1:0] a, ea; int d0;
    d0 = done_cnt[2];
    q_req_addr.delete();
    @(negedge clock);
    arm(2, 29'h1FFF_FFFF, 16'd2, 1'b1);
    @(negedge clock);
    base_valid = '0;
    for (int k = 0; k < 6; k++) begin
      ea = (k % 2 == 0) ? 29'h1FFF_FFFF : 29'h0;
      wait_chunk(2, 50, got, d);
      n_total++;
      if (!got || d !== mem_fn(ea)) $display("FAIL loop_chunk%0d: got %h required %h", k, d, mem_fn(ea));
      else n_pass++;
    end
    stop[2] = 1'b1;
    @(negedge clock);
    stop[2] = 1'b0;
    repeat (10) @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      ea = (k % 2 == 0) ? 29'h1FFF_FFFF : 29'h0;
      a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
      n_total++;
      if (a !== ea) $display("FAIL loop_addr%0d: got %h required %h", k, a, ea); else n_pass++;
    end
    n_total++;
    if (done_cnt[2] != d0 || chunk_valid[2] !== 1'b0 || base_ack[2] !== 1'b1)
      $display("FAIL loop_no_done: got pulses=%0d cv=%b ack=%b required 0 0 1", done_cnt[2] - d0, chunk_valid[2], base_ack[2]);
    else n_pass++;
    q_req_addr.delete();
  endtask

  task automatic test_wait_toggle();
    logic prev_pend; logic [AW-1:0] prev_addr, a; logic [DW-1:0] e; int got, d0;
    prev_pend = 1'b0; prev_addr = '0; got = 0; d0 = done_cnt[3];
    for (int k = 0; k < 5; k++) q_exp_data.push_back(mem_fn(AW'(32'h55 + k)));
    wait_toggle = 1'b1;
    @(negedge clock);
    arm(3, 29'h55, 16'd5, 1'b0);
    @(negedge clock);
    base_valid = '0;
    for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
      @(negedge clock);
      #1;
      chunk_ack[3] = 1'b0;
      if (prev_pend) begin
        n_total++;
        if (mem_read_en !== 1'b1 || mem_addr !== prev_addr)
          $display("FAIL wait_hold: got rd=%b addr=%h required rd=1 addr=%h", mem_read_en, mem_addr, prev_addr);
        else n_pass++;
      end
      prev_pend = mem_read_en && mem_wait;
      prev_addr = mem_addr;
      if (chunk_valid[3]) begin
        e = q_exp_data.pop_front();
        n_total++;
        if (chunk[3*DW +: DW] !== e) $display("FAIL wait_chunk%0d: got %h required %h", got, chunk[3*DW +: DW], e);
        else n_pass++;
        got++;
        chunk_ack[3] = 1'b1;
      end
    end
    @(negedge clock);
    chunk_ack[3] = 1'b0;
    wait_toggle = 1'b0;
    repeat (6) @(negedge clock);
    n_total++;
    if (got != 5 || q_req_addr.size() != 5)
      $display("FAIL wait_counts: got chunks=%0d reads=%0d required 5 5", got, q_req_addr.size());
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
      n_total++;
      if (a !== AW'(32'h55 + k)) $display("FAIL wait_addr%0d: got %h required %h", k, a, AW'(32'h55 + k));
      else n_pass++;
    end
    n_total++;
    if (done_cnt[3] - d0 != 1) $display("FAIL wait_done: got %0d required 1", done_cnt[3] - d0); else n_pass++;
    q_req_addr.delete();
  endtask

  task automatic test_stop_inflight();
    bit seen; logic [AW-1:0] a; int d0;
    d0 = done_cnt[0];
    ack_delay = 4;
    @(negedge clock);
    arm(0, 29'h300, 16'd4, 1'b0);
    @(negedge clock);
    base_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (mem_read_en === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    n_total++;
    if (!seen) $display("FAIL stop_req_seen: got no read required a read"); else n_pass++;
    @(negedge clock);
    stop[0] = 1'b1;
    @(negedge clock);
    stop[0] = 1'b0;
    n_total++;
    if (base_ack[0] !== 1'b0) $display("FAIL stop_ack_inflight: got %b required 0", base_ack[0]); else n_pass++;
    repeat (6) @(negedge clock);
    n_total++;
    if (chunk_valid[0] !== 1'b0 || base_ack[0] !== 1'b1 || mem_read_en !== 1'b0)
      $display("FAIL stop_discard: got cv=%b ack=%b rd=%b required 0 1 0", chunk_valid[0], base_ack[0], mem_read_en);
    else n_pass++;
    a = (q_req_addr.size() > 0) ? q_req_addr.pop_front() : 'x;
    n_total++;
    if (a !== 29'h300 || q_req_addr.size() != 0 || done_cnt[0] != d0)
      $display("FAIL stop_reads: got addr=%h extra=%0d done=%0d required 300 0 0", a, q_req_addr.size(), done_cnt[0] - d0);
    else n_pass++;
  endtask

  task automatic test_reset_midread();
    bit seen;
    ack_delay = 4;
    @(negedge clock);
    arm(1, 29'h10, 16'd3, 1'b0);
    @(negedge clock);
    base_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (mem_read_en === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (!seen || {mem_read_en, mem_addr, base_ack, chunk_valid, done} !== '0 || chunk !== '0)
      $display("FAIL midread_reset: got seen=%b rd=%b addr=%h ack=%b cv=%b required all 0",
               seen, mem_read_en, mem_addr, base_ack, chunk_valid);
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    n_total++;
    if (chunk_valid !== '0 || mem_read_en !== 1'b0 || base_ack !== 4'hF)
      $display("FAIL midread_late_ack: got cv=%b rd=%b ack=%b required 0000 0 1111", chunk_valid, mem_read_en, base_ack);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_loop();
    test_wait_toggle();
    test_stop_inflight();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_sample_fetcher.md
# multi_sample_fetcher

Multi-channel successor to the APU sample fetcher: streams 64-bit sample chunks from SDRAM into per-channel FIFOs for the audio mixer. Each channel is armed with a base address, a chunk count and a loop flag; one shared memory read port is round-robin arbitrated between channels with FIFO space. Sits between the APU register file (channel arming) and the per-voice mixers (chunk consumers).

## Interface
- CHANNELS, 4: number of independent sample streams (1..8)
- DATA_W, 64: memory/chunk width
- ADDR_W, 29: memory word address width
- LEN_W, 16: chunk-count width
- FIFO_DEPTH, 4: chunks buffered per channel (power of two, ≥2)
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- base  in  CHANNELS*ADDR_W  per-channel start word address (slice i)
- length  in  CHANNELS*LEN_W  per-channel chunk count; 0 means 2^LEN_W
- loop  in  CHANNELS  per-channel: restart at base after last chunk
- base_valid  in  CHANNELS  arm request
- base_ack  out  CHANNELS  arm accepted (combinational = channel idle)
- stop  in  CHANNELS  abort channel, flush its FIFO
- done  out  CHANNELS  one-cycle pulse: non-loop channel issued its last chunk
- chunk  out  CHANNELS*DATA_W  FIFO head per channel
- chunk_valid  out  CHANNELS  FIFO i non-empty
- chunk_ack  in  CHANNELS  pop FIFO i when valid & ack
- mem_addr  out  ADDR_W  read address
- mem_read_en  out  1  read request
- mem_wait  in  1  request not accepted this cycle
- mem_data  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  read data return

## Operation
- Channel state: active, cur_addr, remaining, credits (FIFO count + in-flight).
- Arm: base_valid[i] & base_ack[i] → active=1, cur_addr=base, remaining=length. FIFO contents kept.
- Eligible: active & credits < FIFO_DEPTH.
- Arbiter FSM: IDLE → (any eligible) REQ, latching the winner (round-robin, starting after last granted) and its cur_addr. REQ: mem_read_en=1; mem_wait=0 → WAIT_DATA. WAIT_DATA: mem_ack → push mem_data into winner's FIFO, cur_addr+1 (wraps mod 2^ADDR_W), remaining−1 → IDLE. One outstanding read max.
- Last chunk (remaining 1→0): loop=1 → cur_addr=base, remaining=length (sampled now); loop=0 → active=0, done pulse.
- stop[i]: active=0, FIFO flushed same cycle; if i is in flight, returned data is discarded (no push), FSM completes normally. stop wins over same-cycle base_valid and chunk_ack.
- base_ack[i]=!active[i] & !(in-flight owner==i).
- mem_ack outside WAIT_DATA ignored.

## Timing
- Reset: all outputs 0; FSM IDLE; FIFOs empty; round-robin pointer 0; base_ack all 1 after reset deasserts.
- Arm to mem_read_en: 2 cycles (arm edge, IDLE→REQ edge).
- mem_ack to chunk_valid: 1 cycle (registered push).
- Back-to-back: IDLE is one cycle between reads; min 3 cycles per chunk.
- Full FIFO + pop same cycle: pop frees credit next cycle; push never overflows (credit reserved at grant).
- Reset mid-read: FSM to IDLE immediately; late mem_ack ignored.

## Structure
- Package apu_fetch_pkg: fetch_state_t enum (IDLE, REQ, WAIT_DATA), default parameter constants.
- Sub-module chunk_fifo (DATA_W, FIFO_DEPTH): sync FIFO with push, pop, flush, count; instantiated CHANNELS times via generate.
- Round-robin arbiter inline.

## Test plan
- Single channel: base=0x100, length=3, loop=0, mem_wait=0, mem_ack 2 cycles after accept → addrs 0x100,0x101,0x102; 3 chunks = mem_data; done pulse once; base_ack returns high.
- Backpressure: chunk_ack=0, FIFO_DEPTH=4, length=10 → exactly 4 reads issued then mem_read_en stays 0; one pop → exactly one more read.
- Round-robin: 4 channels armed same cycle, bases 0x000/0x100/0x200/0x300 → grant order ch0,1,2,3,0,...
- Loop: base=0x1FFFFFFF, length=2, loop=1 → addrs 0x1FFFFFFF,0x00000000,0x1FFFFFFF,...; no done.
- mem_wait toggling every 3 cycles → mem_addr and mem_read_en stable until accepted; no duplicate or lost chunk.
- stop during WAIT_DATA for owning channel → returned data not pushed, chunk_valid 0, base_ack high after mem_ack; reset mid-read → all outputs 0 next cycle.
